pam4_ber_checker: RTL

PAM4_BER_CHECKER -- requirements
Module: pam4_ber_checker

---
 rtl/pam4_ber_checker.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/pam4_ber_checker.sv
// PAM4 bit-error-rate checker.
//
// Decodes each valid PAM4 symbol from the DFE, self-synchronises a reference PRBS7
// (x^7 + x^6 + 1) to the incoming stream, verifies the lock, and then counts compared
// bits, bit errors and illegal levels while locked. Lock drops after a run of
// consecutive errored symbols.
//
// Ports:
//   clk             - single clock, rising edge
//   rst             - asynchronous active-high reset
//   symbol_in       - signed decided level from the DFE
//   symbol_in_valid - qualifies symbol_in
//   clear_counters  - synchronous clear of the three statistics counters
//   locked          - high while in the LOCKED state
//   lock_lost       - one-cycle pulse when lock is dropped by errors
//   sym_err         - one-cycle pulse on a compared symbol mismatch
//   bit_count       - bits compared while locked (saturating)
//   bit_err_count   - bit errors while locked (saturating)
//   illegal_count   - illegal-level symbols while locked (saturating)
module pam4_ber_checker #(
    parameter int unsigned SIGNAL_RESOLUTION = 8,
    parameter int unsigned SYMBOL_SEPERATION = 56,
    parameter int unsigned LOCK_COUNT        = 16,
    parameter int unsigned UNLOCK_ERRORS     = 8,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [SIGNAL_RESOLUTION-1:0] symbol_in,
    input  logic                                symbol_in_valid,
    input  logic                                clear_counters,
    output logic                                locked,
    output logic                                lock_lost,
    output logic                                sym_err,
    output logic [CNT_WIDTH-1:0]                bit_count,
    output logic [CNT_WIDTH-1:0]                bit_err_count,
    output logic [CNT_WIDTH-1:0]                illegal_count
);

    localparam int LvlInner = int'(SYMBOL_SEPERATION) / 2;
    localparam int LvlOuter = (3 * int'(SYMBOL_SEPERATION)) / 2;

    localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned ErrW   = $clog2(UNLOCK_ERRORS + 1);

    localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_COUNT - 1);
    localparam logic [ErrW-1:0]   ErrLast   = ErrW'(UNLOCK_ERRORS - 1);

    typedef enum logic [1:0] {
        StSeed,
        StVerify,
        StLocked
    } state_e;

    state_e              state_q, state_d;
    logic [6:0]          prbs_q, prbs_d;
    logic [1:0]          seed_cnt_q, seed_cnt_d;
    logic [MatchW-1:0]   match_cnt_q, match_cnt_d;
    logic [ErrW-1:0]     err_run_q, err_run_d;
    logic                locked_q, lock_lost_q, lock_lost_d, sym_err_q, sym_err_d;
    logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_WIDTH-1:0] bit_err_q, bit_err_d;
    logic [CNT_WIDTH-1:0] ill_q, ill_d;

    // ------------------------------------------------------------------
    // Symbol decode (Gray mapped, bit[1] first in time)
    // ------------------------------------------------------------------
    logic signed [31:0] sym_ext;
    logic [1:0]         rx_bits;
    logic               illegal;

    assign sym_ext = 32'(symbol_in);

    always_comb begin
        rx_bits = 2'b00;
        illegal = 1'b0;
        if (sym_ext == -LvlOuter) begin
            rx_bits = 2'b00;
        end else if (sym_ext == -LvlInner) begin
            rx_bits = 2'b01;
        end else if (sym_ext == LvlInner) begin
            rx_bits = 2'b11;
        end else if (sym_ext == LvlOuter) begin
            rx_bits = 2'b10;
        end else begin
            illegal = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Reference PRBS7: two expected bits per symbol and the advanced state
    // ------------------------------------------------------------------
    logic [6:0] prbs_mid, prbs_adv;
    logic [1:0] exp_bits;

    always_comb begin
        exp_bits[1] = prbs_q[6] ^ prbs_q[5];
        prbs_mid    = {prbs_q[5:0], exp_bits[1]};
        exp_bits[0] = prbs_mid[6] ^ prbs_mid[5];
        prbs_adv    = {prbs_mid[5:0], exp_bits[0]};
    end

    // An illegal level is always an errored symbol worth two bit errors.
    logic [1:0] bit_diff;
    logic [1:0] n_err;
    logic       sym_bad;

    assign bit_diff = rx_bits ^ exp_bits;
    assign sym_bad  = illegal || (bit_diff != 2'b00);
    assign n_err    = illegal ? 2'd2 : ({1'b0, bit_diff[1]} + {1'b0, bit_diff[0]});

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [1:0]           inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(CNT_WIDTH - 1){1'b0}}, inc};
        if (sum[CNT_WIDTH]) begin
            return '1;
        end
        return sum[CNT_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        prbs_d      = prbs_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        err_run_d   = err_run_q;
        sym_err_d   = 1'b0;
        lock_lost_d = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        bit_err_d   = bit_err_q;
        ill_d       = ill_q;

        if (symbol_in_valid) begin
            unique case (state_q)
                StSeed: begin
                    prbs_d = {prbs_q[4:0], rx_bits};
                    if (seed_cnt_q == 2'd3) begin
                        state_d     = StVerify;
                        seed_cnt_d  = 2'd0;
                        match_cnt_d = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + 2'd1;
                    end
                end
                StVerify: begin
                    prbs_d = prbs_adv;
                    if (sym_bad) begin
                        sym_err_d   = 1'b1;
                        state_d     = StSeed;
                        seed_cnt_d  = 2'd0;
                        match_cnt_d = '0;
                    end else if (match_cnt_q == MatchLast) begin
                        state_d     = StLocked;
                        match_cnt_d = '0;
                        err_run_d   = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + MatchW'(1);
                    end
                end
                StLocked: begin
                    // Advance on expected bits so a received error never corrupts s.
                    prbs_d    = prbs_adv;
                    bit_cnt_d = sat_add(bit_cnt_q, 2'd2);
                    bit_err_d = sat_add(bit_err_q, n_err);
                    if (illegal) begin
                        ill_d = sat_add(ill_q, 2'd1);
                    end
                    if (sym_bad) begin
                        sym_err_d = 1'b1;
                        if (err_run_q == ErrLast) begin
                            state_d     = StSeed;
                            lock_lost_d = 1'b1;
                            seed_cnt_d  = 2'd0;
                            err_run_d   = '0;
                        end else begin
                            err_run_d = err_run_q + ErrW'(1);
                        end
                    end else begin
                        err_run_d = '0;
                    end
                end
                default: begin
                    state_d = StSeed;
                end
            endcase
        end

        // Clear wins over the symbol's count update; FSM effects above still apply.
        if (clear_counters) begin
            bit_cnt_d = '0;
            bit_err_d = '0;
            ill_d     = '0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StSeed;
            prbs_q      <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            err_run_q   <= '0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            sym_err_q   <= 1'b0;
            bit_cnt_q   <= '0;
            bit_err_q   <= '0;
            ill_q       <= '0;
        end else begin
            state_q     <= state_d;
            prbs_q      <= prbs_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            err_run_q   <= err_run_d;
            locked_q    <= (state_d == StLocked);
            lock_lost_q <= lock_lost_d;
            sym_err_q   <= sym_err_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_err_q   <= bit_err_d;
            ill_q       <= ill_d;
        end
    end

    assign locked        = locked_q;
    assign lock_lost     = lock_lost_q;
    assign sym_err       = sym_err_q;
    assign bit_count     = bit_cnt_q;
    assign bit_err_count = bit_err_q;
    assign illegal_count = ill_q;

endmodule
